// File: rtl/pic_pkg.sv
// Shared constants, OCW2 command codes and FSM states for the interrupt acknowledge sequencer.
package pic_pkg;

   localparam int NUM_IR = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK1,
      ST_GAP,
      ST_ACK2
   } pic_state_t;

   localparam logic [2:0] OCW2_NS_EOI     = 3'b001;
   localparam logic [2:0] OCW2_SP_EOI     = 3'b011;
   localparam logic [2:0] OCW2_ROT_NS_EOI = 3'b101;
   localparam logic [2:0] OCW2_SET_PRI    = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP_EOI = 3'b111;

   // Rank 0 is the highest priority: the level just above the lowest-priority one.
   function automatic logic [2:0] rank_of(input logic [2:0] level, input logic [2:0] lowest);
      return level - lowest - 3'd1;
   endfunction

endpackage

// File: rtl/priority_resolver.sv
// Combinational resolver: index of the highest-priority set bit of vec, given which level
// is currently lowest priority (priority rises from lowest+1 upward, wrapping).
module priority_resolver
   import pic_pkg::*;
(
   input  logic [NUM_IR-1:0] vec,
   input  logic [2:0]        lowest,
   output logic [2:0]        idx,
   output logic              valid
);

   logic [NUM_IR-1:0] rot;
   logic [2:0]        k;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IR; gi++) begin : g_rot
         logic [2:0] sel;
         assign sel     = lowest + 3'(gi + 1);
         assign rot[gi] = vec[sel];
      end
   endgenerate

   always_comb begin
      k     = '0;
      valid = 1'b0;
      for (int i = NUM_IR - 1; i >= 0; i--) begin
         if (rot[i]) begin
            k     = 3'(i);
            valid = 1'b1;
         end
      end
   end

   assign idx = lowest + k + 3'd1;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Two-pulse INTA acknowledge sequencer with ISR, EOI handling and vector drive.
// Optional rotating priority commands are enabled by defining PIC_ROTATE_EN.
module interrupt_ack_sequencer
   import pic_pkg::*;
#(
   parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        INTA_n,
   input  logic        icw1_write,
   input  logic [7:0]  ICW2,
   input  logic [7:0]  ICW4,
   input  logic [7:0]  OCW1,
   input  logic [7:0]  OCW2,
   input  logic        ocw2_write,
   input  logic [7:0]  IRR,
   output logic        INT,
   output logic [7:0]  ISR,
   output logic [7:0]  irr_clear,
   output logic [7:0]  vector_out,
   output logic        vector_en
);

   pic_state_t        state_reg;
   logic              prev_inta_reg;
   logic [2:0]        level_reg;
   logic              spurious_reg;
   logic [2:0]        lowest_reg;
   logic [NUM_IR-1:0] isr_reg;
   logic              int_reg;
   logic [NUM_IR-1:0] irr_clear_reg;
   logic [7:0]        vector_out_reg;
   logic              vector_en_reg;

   logic [NUM_IR-1:0] req;
   logic [2:0]        req_idx, isr_idx;
   logic              req_valid, isr_valid;
   logic              inta_fall, inta_rise;
   logic              int_next;
   logic [NUM_IR-1:0] eoi_clear, aeoi_clear, ack_set, isr_next;
   logic [2:0]        lowest_next;
   logic [NUM_IR-1:0] one;
   logic              unused_bits;

   assign one         = {{(NUM_IR - 1){1'b0}}, 1'b1};
   assign unused_bits = ^{ICW2[2:0], ICW4[7:2], ICW4[0], OCW2[4:3]};

   assign req       = IRR & ~OCW1;
   assign inta_fall = prev_inta_reg & ~INTA_n;
   assign inta_rise = ~prev_inta_reg & INTA_n;

   priority_resolver u_req_res (.vec(req),     .lowest(lowest_reg), .idx(req_idx), .valid(req_valid));
   priority_resolver u_isr_res (.vec(isr_reg), .lowest(lowest_reg), .idx(isr_idx), .valid(isr_valid));

   // Fully nested: only a request strictly above everything in service raises INT.
   assign int_next = req_valid &&
                     (!isr_valid || (rank_of(req_idx, lowest_reg) < rank_of(isr_idx, lowest_reg)));

   always_comb begin
      eoi_clear   = '0;
      lowest_next = lowest_reg;
      if (ocw2_write) begin
         case (OCW2[7:5])
            OCW2_NS_EOI: if (isr_valid) eoi_clear[isr_idx] = 1'b1;
            OCW2_SP_EOI: eoi_clear[OCW2[2:0]] = 1'b1;
`ifdef PIC_ROTATE_EN
            OCW2_ROT_NS_EOI: begin
               if (isr_valid) begin
                  eoi_clear[isr_idx] = 1'b1;
                  lowest_next        = isr_idx;
               end
            end
            OCW2_ROT_SP_EOI: begin
               eoi_clear[OCW2[2:0]] = 1'b1;
               lowest_next          = OCW2[2:0];
            end
            OCW2_SET_PRI: lowest_next = OCW2[2:0];
`endif
            default: ;
         endcase
      end
   end

   assign ack_set    = (state_reg == ST_IDLE && inta_fall && req_valid) ? (one << req_idx) : '0;
   assign aeoi_clear = (state_reg == ST_ACK2 && inta_rise && ICW4[1] && !spurious_reg)
                       ? (one << level_reg) : '0;
   // Clears are applied before the acknowledge set, so a same-bit set survives.
   assign isr_next   = (isr_reg & ~eoi_clear & ~aeoi_clear) | ack_set;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         prev_inta_reg  <= 1'b1;
         level_reg      <= 3'd0;
         spurious_reg   <= 1'b0;
         lowest_reg     <= 3'd7;
         isr_reg        <= '0;
         int_reg        <= 1'b0;
         irr_clear_reg  <= '0;
         vector_out_reg <= 8'h00;
         vector_en_reg  <= 1'b0;
      end else begin
         prev_inta_reg <= INTA_n;
         int_reg       <= int_next;
         irr_clear_reg <= '0;
         if (icw1_write) begin
            state_reg     <= ST_IDLE;
            isr_reg       <= '0;
            vector_en_reg <= 1'b0;
            lowest_reg    <= 3'd7;
         end else begin
            isr_reg    <= isr_next;
            lowest_reg <= lowest_next;
            case (state_reg)
               ST_IDLE: begin
                  if (inta_fall) begin
                     state_reg     <= ST_ACK1;
                     level_reg     <= req_valid ? req_idx : SPURIOUS_LEVEL;
                     spurious_reg  <= !req_valid;
                     irr_clear_reg <= ack_set;
                  end
               end
               ST_ACK1: if (inta_rise) state_reg <= ST_GAP;
               ST_GAP: begin
                  if (inta_fall) begin
                     state_reg      <= ST_ACK2;
                     vector_out_reg <= {ICW2[7:3], level_reg};
                     vector_en_reg  <= 1'b1;
                  end
               end
               ST_ACK2: begin
                  if (inta_rise) begin
                     state_reg     <= ST_IDLE;
                     vector_en_reg <= 1'b0;
                  end
               end
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   assign INT        = int_reg;
   assign ISR        = isr_reg;
   assign irr_clear  = irr_clear_reg;
   assign vector_out = vector_out_reg;
   assign vector_en  = vector_en_reg;

endmodule
